// File: rtl/bp_cache_req_arbiter.sv
// bp_cache_req_arbiter
//   Shares one cache-engine request channel between the I$ and D$ miss
//   interfaces. Grants round-robin, forwards the winner's request (0-cycle,
//   ungated by a register), then holds ownership through the metadata phase
//   and until the engine reports the transaction complete.
//
// Ports
//   clk_i, reset_i           clock, synchronous active-high reset
//   icache_req_*/dcache_req_* per-cache request, metadata, yumi and last
//   req_o, req_v_o, req_yumi_i                 request channel to the engine
//   req_metadata_o, req_metadata_v_o           metadata channel to the engine
//   req_last_i               engine: owner's transaction is complete
//   req_credits_full_i       engine cannot accept a new request
//   owner_o                  registered owner, 0 = I$, 1 = D$
module bp_cache_req_arbiter #(
  parameter int req_width_p      = 64,
  parameter int metadata_width_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic [req_width_p-1:0]      icache_req_i,
  input  logic                        icache_req_v_i,
  output logic                        icache_req_yumi_o,
  input  logic [metadata_width_p-1:0] icache_req_metadata_i,
  input  logic                        icache_req_metadata_v_i,
  output logic                        icache_req_last_o,

  input  logic [req_width_p-1:0]      dcache_req_i,
  input  logic                        dcache_req_v_i,
  output logic                        dcache_req_yumi_o,
  input  logic [metadata_width_p-1:0] dcache_req_metadata_i,
  input  logic                        dcache_req_metadata_v_i,
  output logic                        dcache_req_last_o,

  output logic [req_width_p-1:0]      req_o,
  output logic                        req_v_o,
  input  logic                        req_yumi_i,
  output logic [metadata_width_p-1:0] req_metadata_o,
  output logic                        req_metadata_v_o,
  input  logic                        req_last_i,
  input  logic                        req_credits_full_i,

  output logic                        owner_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] META = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;

  logic [1:0] state_r, state_n;
  logic       rr_r;
  logic       owner_r;
  logic       winner;
  logic       grant;
  logic       in_meta;
  logic       owner_md_v;
  logic       done;

  always_comb begin
    // Round-robin only breaks ties; a lone requester always wins.
    winner     = (icache_req_v_i & dcache_req_v_i) ? rr_r : dcache_req_v_i;
    owner_md_v = owner_r ? dcache_req_metadata_v_i : icache_req_metadata_v_i;
    in_meta    = (state_r == META);

    req_v_o = (state_r == IDLE) & (icache_req_v_i | dcache_req_v_i)
            & ~req_credits_full_i;
    // Mask the request bus so a losing cache's payload never leaks out.
    req_o   = req_v_o ? (winner ? dcache_req_i : icache_req_i) : '0;

    grant             = req_v_o & req_yumi_i;
    icache_req_yumi_o = grant & ~winner;
    dcache_req_yumi_o = grant &  winner;

    req_metadata_v_o = in_meta & owner_md_v;
    req_metadata_o   = in_meta ? (owner_r ? dcache_req_metadata_i
                                          : icache_req_metadata_i) : '0;

    // Completion counts in BUSY, or in META when it coincides with metadata.
    done              = req_last_i & ((state_r == BUSY) | (in_meta & owner_md_v));
    icache_req_last_o = done & ~owner_r;
    dcache_req_last_o = done &  owner_r;

    state_n = state_r;
    case (state_r)
      IDLE:    if (grant) state_n = META;
      META:    if (owner_md_v) state_n = req_last_i ? IDLE : BUSY;
      BUSY:    if (req_last_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      rr_r    <= 1'b0;
      owner_r <= 1'b0;
    end else begin
      state_r <= state_n;
      if (grant) begin
        owner_r <= winner;
        rr_r    <= ~winner;
      end
    end
  end

  assign owner_o = owner_r;

  a_yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) req_yumi_i |-> req_v_o);

  a_no_last_in_idle: assert property (
    @(posedge clk_i) disable iff (reset_i) (state_r == IDLE) |-> !req_last_i);

endmodule

// File: tb/tb_bp_cache_req_arbiter.sv
module tb_bp_cache_req_arbiter;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [63:0] icache_req_i = '0, dcache_req_i = '0;
  logic        icache_req_v_i = 1'b0, dcache_req_v_i = 1'b0;
  logic [7:0]  icache_req_metadata_i = 8'h11, dcache_req_metadata_i = 8'h22;
  logic        icache_req_metadata_v_i = 1'b0, dcache_req_metadata_v_i = 1'b0;
  logic        req_yumi_i = 1'b0, req_last_i = 1'b0, req_credits_full_i = 1'b0;
  logic        icache_req_yumi_o, dcache_req_yumi_o;
  logic        icache_req_last_o, dcache_req_last_o;
  logic [63:0] req_o;
  logic        req_v_o, req_metadata_v_o, owner_o;
  logic [7:0]  req_metadata_o;

  always #5 clk = ~clk;

  bp_cache_req_arbiter #(.req_width_p(64), .metadata_width_p(8)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .icache_req_i(icache_req_i), .icache_req_v_i(icache_req_v_i),
    .icache_req_yumi_o(icache_req_yumi_o),
    .icache_req_metadata_i(icache_req_metadata_i),
    .icache_req_metadata_v_i(icache_req_metadata_v_i),
    .icache_req_last_o(icache_req_last_o),
    .dcache_req_i(dcache_req_i), .dcache_req_v_i(dcache_req_v_i),
    .dcache_req_yumi_o(dcache_req_yumi_o),
    .dcache_req_metadata_i(dcache_req_metadata_i),
    .dcache_req_metadata_v_i(dcache_req_metadata_v_i),
    .dcache_req_last_o(dcache_req_last_o),
    .req_o(req_o), .req_v_o(req_v_o), .req_yumi_i(req_yumi_i),
    .req_metadata_o(req_metadata_o), .req_metadata_v_o(req_metadata_v_o),
    .req_last_i(req_last_i), .req_credits_full_i(req_credits_full_i),
    .owner_o(owner_o)
  );

  // ctl = {req_v, icache_yumi, dcache_yumi, md_v, icache_last, dcache_last, owner}
  typedef struct {
    string       name;
    logic        rst, iv, dv;
    logic [63:0] ireq, dreq;
    logic        imdv, dmdv, yumi, last, full;
    logic [6:0]  ctl;
    logic [63:0] req;
    logic [7:0]  md;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(string name, logic rst, logic iv, logic dv,
                              logic [63:0] ireq, logic [63:0] dreq,
                              logic imdv, logic dmdv, logic yumi, logic last,
                              logic full, logic [6:0] ctl, logic [63:0] req,
                              logic [7:0] md);
    vec_t v;
    v.name = name; v.rst = rst; v.iv = iv; v.dv = dv; v.ireq = ireq;
    v.dreq = dreq; v.imdv = imdv; v.dmdv = dmdv; v.yumi = yumi;
    v.last = last; v.full = full; v.ctl = ctl; v.req = req; v.md = md;
    return v;
  endfunction

  function automatic logic [6:0] got_ctl();
    return {req_v_o, icache_req_yumi_o, dcache_req_yumi_o, req_metadata_v_o,
            icache_req_last_o, dcache_req_last_o, owner_o};
  endfunction

  task automatic drive(input vec_t v);
    reset_i = v.rst; icache_req_v_i = v.iv; dcache_req_v_i = v.dv;
    icache_req_i = v.ireq; dcache_req_i = v.dreq;
    icache_req_metadata_v_i = v.imdv; dcache_req_metadata_v_i = v.dmdv;
    req_yumi_i = v.yumi; req_last_i = v.last; req_credits_full_i = v.full;
  endtask

  task automatic check(input string name, input logic [6:0] ctl,
                       input logic [63:0] req, input logic [7:0] md);
    checks++;
    if (got_ctl() !== ctl || req_o !== req || req_metadata_o !== md) begin
      failures++;
      $display("FAIL %s: got ctl=%b req=%h md=%h, expected ctl=%b req=%h md=%h",
               name, got_ctl(), req_o, req_metadata_o, ctl, req, md);
    end
  endtask

  initial begin
    // Test 1: I$ alone
    vecs.push_back(mk("reset",       1,0,0, 64'h0, 64'h0, 0,0,0,0,0, 7'b0000000, 64'h0, 8'h00));
    vecs.push_back(mk("t1_req",      0,1,0, 64'hA1,64'h0, 0,0,0,0,0, 7'b1000000, 64'hA1,8'h00));
    vecs.push_back(mk("t1_yumi",     0,1,0, 64'hA1,64'h0, 0,0,1,0,0, 7'b1100000, 64'hA1,8'h00));
    vecs.push_back(mk("t1_md_wait",  0,0,0, 64'h0, 64'h0, 0,1,0,0,0, 7'b0000000, 64'h0, 8'h11));
    vecs.push_back(mk("t1_md",       0,0,0, 64'h0, 64'h0, 1,0,0,0,0, 7'b0001000, 64'h0, 8'h11));
    vecs.push_back(mk("t1_busy1",    0,0,0, 64'h0, 64'h0, 0,0,0,0,0, 7'b0000000, 64'h0, 8'h00));
    vecs.push_back(mk("t1_busy2",    0,0,0, 64'h0, 64'h0, 0,0,0,0,0, 7'b0000000, 64'h0, 8'h00));
    vecs.push_back(mk("t1_last",     0,0,0, 64'h0, 64'h0, 0,0,0,1,0, 7'b0000100, 64'h0, 8'h00));
    vecs.push_back(mk("t1_idle",     0,0,0, 64'h0, 64'h0, 0,0,0,0,0, 7'b0000000, 64'h0, 8'h00));
    // Test 2: both valid, round-robin
    vecs.push_back(mk("t2_reset",    1,0,0, 64'h0, 64'h0, 0,0,0,0,0, 7'b0000000, 64'h0, 8'h00));
    vecs.push_back(mk("t2_g1",       0,1,1, 64'hA1,64'hD2,0,0,1,0,0, 7'b1100000, 64'hA1,8'h00));
    vecs.push_back(mk("t2_m1",       0,1,1, 64'hA1,64'hD2,1,0,0,1,0, 7'b0001100, 64'h0, 8'h11));
    vecs.push_back(mk("t2_g2",       0,1,1, 64'hA3,64'hD4,0,0,1,0,0, 7'b1010000, 64'hD4,8'h00));
    vecs.push_back(mk("t2_m2_wait",  0,1,1, 64'hA3,64'hD4,1,0,0,0,0, 7'b0000001, 64'h0, 8'h22));
    vecs.push_back(mk("t2_m2",       0,1,1, 64'hA3,64'hD4,0,1,0,0,0, 7'b0001001, 64'h0, 8'h22));
    vecs.push_back(mk("t2_last2",    0,1,1, 64'hA3,64'hD4,0,0,0,1,0, 7'b0000011, 64'h0, 8'h00));
    vecs.push_back(mk("t2_g3",       0,1,1, 64'hA5,64'hD6,0,0,1,0,0, 7'b1100001, 64'hA5,8'h00));
    vecs.push_back(mk("t2_m3",       0,1,1, 64'hA5,64'hD6,1,0,0,1,0, 7'b0001100, 64'h0, 8'h11));
    vecs.push_back(mk("t2_g4",       0,1,1, 64'hA7,64'hD8,0,0,1,0,0, 7'b1010000, 64'hD8,8'h00));
    vecs.push_back(mk("t2_m4",       0,0,0, 64'h0, 64'h0, 0,1,0,1,0, 7'b0001011, 64'h0, 8'h22));
    // Test 3: credits full blocks issue
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk("t3_full",   0,1,1, 64'hA9,64'hDA,0,0,0,0,1, 7'b0000001, 64'h0, 8'h00));
    vecs.push_back(mk("t3_release",  0,1,1, 64'hA9,64'hDA,0,0,1,0,0, 7'b1100001, 64'hA9,8'h00));
    vecs.push_back(mk("t3_m_full",   0,0,0, 64'h0, 64'h0, 1,0,0,1,1, 7'b0001100, 64'h0, 8'h11));
    // Test 4: D$ busy, I$ waits
    vecs.push_back(mk("t4_grant_d",  0,1,1, 64'hAB,64'hDC,0,0,1,0,0, 7'b1010000, 64'hDC,8'h00));
    vecs.push_back(mk("t4_meta",     0,0,0, 64'h0, 64'h0, 0,1,0,0,1, 7'b0001001, 64'h0, 8'h22));
    vecs.push_back(mk("t4_busy_iv",  0,1,0, 64'hAD,64'h0, 0,0,0,0,0, 7'b0000001, 64'h0, 8'h00));
    vecs.push_back(mk("t4_busy_iv2", 0,1,0, 64'hAD,64'h0, 0,0,0,0,0, 7'b0000001, 64'h0, 8'h00));
    vecs.push_back(mk("t4_last",     0,1,0, 64'hAD,64'h0, 0,0,0,1,0, 7'b0000011, 64'h0, 8'h00));
    vecs.push_back(mk("t4_grant_i",  0,1,0, 64'hAD,64'h0, 0,0,1,0,0, 7'b1100001, 64'hAD,8'h00));
    // Test 5: reset mid-transaction
    vecs.push_back(mk("t5_meta",     0,0,0, 64'h0, 64'h0, 1,0,0,0,0, 7'b0001000, 64'h0, 8'h11));
    vecs.push_back(mk("t5_busy1",    0,0,0, 64'h0, 64'h0, 0,0,0,0,0, 7'b0000000, 64'h0, 8'h00));
    vecs.push_back(mk("t5_busy2",    0,0,0, 64'h0, 64'h0, 0,0,0,0,0, 7'b0000000, 64'h0, 8'h00));
    vecs.push_back(mk("t5_reset",    1,0,0, 64'h0, 64'h0, 0,0,0,0,0, 7'b0000000, 64'h0, 8'h00));
    vecs.push_back(mk("t5_after",    0,0,0, 64'h0, 64'h0, 0,0,0,0,0, 7'b0000000, 64'h0, 8'h00));
    vecs.push_back(mk("t5_dual_i",   0,1,1, 64'hAE,64'hDF,0,0,1,0,0, 7'b1100000, 64'hAE,8'h00));
    // Test 6: metadata and last together
    vecs.push_back(mk("t6_md_last",  0,0,1, 64'h0, 64'hDF,1,0,0,1,0, 7'b0001100, 64'h0, 8'h11));
    vecs.push_back(mk("t6_grant_d",  0,0,1, 64'h0, 64'hDF,0,0,1,0,0, 7'b1010000, 64'hDF,8'h00));
    vecs.push_back(mk("t5_meta_d",   0,0,0, 64'h0, 64'h0, 0,1,0,0,0, 7'b0001001, 64'h0, 8'h22));
    vecs.push_back(mk("t5_reset_d",  1,0,0, 64'h0, 64'h0, 0,0,0,0,0, 7'b0000001, 64'h0, 8'h00));
    vecs.push_back(mk("t5_owner_clr",0,0,0, 64'h0, 64'h0, 0,0,0,0,0, 7'b0000000, 64'h0, 8'h00));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check(vecs[i].name, vecs[i].ctl, vecs[i].req, vecs[i].md);
    end

    // Fairness: back-to-back dual requests from reset alternate I, D, I, D...
    @(negedge clk);
    drive(mk("fair_rst", 1,0,0, 64'h0,64'h0, 0,0,0,0,0, 7'b0,64'h0,8'h0));
    for (int k = 0; k < 6; k++) begin
      logic        w;
      logic [63:0] ir, dr;
      w  = k[0];
      ir = 64'h1000 + 64'(k);
      dr = 64'h2000 + 64'(k);
      @(negedge clk);
      drive(mk("fair_g", 0,1,1, ir,dr, 0,0,1,0,0, 7'b0,64'h0,8'h0));
      #1;
      check($sformatf("fair_grant%0d", k),
            {1'b1, ~w, w, 1'b0, 1'b0, 1'b0, (k == 0) ? 1'b0 : ~w},
            w ? dr : ir, 8'h00);
      @(negedge clk);
      drive(mk("fair_m", 0,1,1, ir,dr, 1,1,0,1,0, 7'b0,64'h0,8'h0));
      #1;
      check($sformatf("fair_done%0d", k),
            {1'b0, 1'b0, 1'b0, 1'b1, ~w, w, w},
            64'h0, w ? 8'h22 : 8'h11);
    end

    @(negedge clk);
    drive(mk("end", 0,0,0, 64'h0,64'h0, 0,0,0,0,0, 7'b0,64'h0,8'h0));
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
